// File: rtl/dds_sin_cos_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : dds_sin_cos_datapath_if
// Purpose  : Quarter-wave ROM port bundle between the DDS datapath (master)
//            and a synchronous sin/cos magnitude ROM (slave).
// Revision : 1.0  initial release
// ============================================================================
interface dds_sin_cos_datapath_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
);
  // Registered ROM addresses driven by the datapath
  logic [ADDR_W-1:0] rom_sin_addr_o;
  logic [ADDR_W-1:0] rom_cos_addr_o;
  // Unsigned magnitudes returned by the ROM one cycle after the address
  logic [DATA_W-2:0] rom_sin_data_i;
  logic [DATA_W-2:0] rom_cos_data_i;

  modport master (
    output rom_sin_addr_o,
    output rom_cos_addr_o,
    input  rom_sin_data_i,
    input  rom_cos_data_i
  );

  modport slave (
    input  rom_sin_addr_o,
    input  rom_cos_addr_o,
    output rom_sin_data_i,
    output rom_cos_data_i
  );
endinterface
`default_nettype wire

// File: rtl/dds_sin_cos_datapath.sv
`default_nettype none
// ============================================================================
// Module   : dds_sin_cos_datapath
// Purpose  : DDS phase accumulator with quarter-wave sin/cos folding,
//            sign pipeline aligned to a synchronous ROM, and a strobed
//            output stage producing signed samples plus a valid pulse.
// Revision : 1.0  initial release
// ============================================================================
module dds_sin_cos_datapath #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 12
) (
  input  wire logic                  clk,
  input  wire logic                  rst,        // asynchronous, active-low
  input  wire logic                  freq_clr,
  input  wire logic                  freq_load,
  input  wire logic                  out_clr,
  input  wire logic                  out_load,
  input  wire logic [PHASE_W-1:0]    ftw_i,
  input  wire logic                  ftw_we_i,
  dds_sin_cos_datapath_if.master     rom_if,
  output logic      [DATA_W-1:0]     sin_o,
  output logic      [DATA_W-1:0]     cos_o,
  output logic                       valid_o,
  output logic      [PHASE_W-1:0]    phase_o
);

  // Output-load pipeline depth: strobe capture plus a two-deep delay line,
  // matching phase -> address -> ROM data -> output register.
  localparam int LD_DEPTH = 3;

  // --------------------------------------------------------------------------
  // Frequency / phase state
  // --------------------------------------------------------------------------
  logic [PHASE_W-1:0] ftw_q,   ftw_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  // --------------------------------------------------------------------------
  // Stage 1: folded ROM addresses and sign bits
  // --------------------------------------------------------------------------
  logic [1:0]         quad;
  logic [ADDR_W-1:0]  index;
  logic [ADDR_W-1:0]  sin_addr_q, sin_addr_d;
  logic [ADDR_W-1:0]  cos_addr_q, cos_addr_d;
  logic               sin_sgn1_q, sin_sgn1_d;
  logic               cos_sgn1_q, cos_sgn1_d;

  // --------------------------------------------------------------------------
  // Stage 2: signs delayed to line up with ROM data
  // --------------------------------------------------------------------------
  logic               sin_sgn2_q, sin_sgn2_d;
  logic               cos_sgn2_q, cos_sgn2_d;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]   sin_mag_ext, cos_mag_ext;
  logic [DATA_W-1:0]   sin_samp, cos_samp;
  logic [LD_DEPTH-1:0] ld_q, ld_d;
  logic [DATA_W-1:0]   sin_q, sin_d;
  logic [DATA_W-1:0]   cos_q, cos_d;
  logic                valid_q, valid_d;

  // FTW write is independent of every strobe; the phase update below sees
  // the pre-write value because both read ftw_q.
  always_comb begin
    ftw_d = ftw_q;
    if (ftw_we_i) begin
      ftw_d = ftw_i;
    end
  end

  // Phase accumulator: clear beats load; the carry out of the MSB is dropped.
  always_comb begin
    phase_d = phase_q;
    if (freq_clr) begin
      phase_d = '0;
    end else if (freq_load) begin
      phase_d = phase_q + ftw_q;
    end
  end

  // Split phase into quadrant and truncated table index.
  always_comb begin
    quad  = phase_q[PHASE_W-1 -: 2];
    index = phase_q[PHASE_W-3 -: ADDR_W];
  end

  // Quarter-wave folding: odd quadrants mirror the sin index, cos is the
  // complementary mirror; signs follow the half-plane of each function.
  always_comb begin
    sin_addr_d = quad[0] ? ~index : index;
    cos_addr_d = quad[0] ? index  : ~index;
    sin_sgn1_d = quad[1];
    cos_sgn1_d = quad[1] ^ quad[0];
    sin_sgn2_d = sin_sgn1_q;
    cos_sgn2_d = cos_sgn1_q;
  end

  // Apply the aligned sign to the zero-extended ROM magnitude. The magnitude
  // never reaches 2^(DATA_W-1), so negation cannot overflow.
  always_comb begin
    sin_mag_ext = {1'b0, rom_if.rom_sin_data_i};
    cos_mag_ext = {1'b0, rom_if.rom_cos_data_i};
    sin_samp    = sin_sgn2_q ? ({DATA_W{1'b0}} - sin_mag_ext) : sin_mag_ext;
    cos_samp    = cos_sgn2_q ? ({DATA_W{1'b0}} - cos_mag_ext) : cos_mag_ext;
  end

  // Output stage: out_clr flushes the load pipeline and zeroes the samples;
  // otherwise the oldest load copy captures new samples and pulses valid.
  always_comb begin
    ld_d    = {ld_q[LD_DEPTH-2:0], out_load};
    sin_d   = sin_q;
    cos_d   = cos_q;
    valid_d = 1'b0;
    if (out_clr) begin
      ld_d  = '0;
      sin_d = '0;
      cos_d = '0;
    end else if (ld_q[LD_DEPTH-1]) begin
      sin_d   = sin_samp;
      cos_d   = cos_samp;
      valid_d = 1'b1;
    end
  end

  // FTW and phase registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ftw_q   <= '0;
      phase_q <= '0;
    end else begin
      ftw_q   <= ftw_d;
      phase_q <= phase_d;
    end
  end

  // Address and sign pipeline, updated every cycle regardless of strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sin_addr_q <= '0;
      cos_addr_q <= '0;
      sin_sgn1_q <= 1'b0;
      cos_sgn1_q <= 1'b0;
      sin_sgn2_q <= 1'b0;
      cos_sgn2_q <= 1'b0;
    end else begin
      sin_addr_q <= sin_addr_d;
      cos_addr_q <= cos_addr_d;
      sin_sgn1_q <= sin_sgn1_d;
      cos_sgn1_q <= cos_sgn1_d;
      sin_sgn2_q <= sin_sgn2_d;
      cos_sgn2_q <= cos_sgn2_d;
    end
  end

  // Output registers and load delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q    <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ld_q    <= ld_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      valid_q <= valid_d;
    end
  end

  assign rom_if.rom_sin_addr_o = sin_addr_q;
  assign rom_if.rom_cos_addr_o = cos_addr_q;
  assign sin_o   = sin_q;
  assign cos_o   = cos_q;
  assign valid_o = valid_q;
  assign phase_o = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sin_cos_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sin_cos_datapath
// Purpose  : Self-checking bench for dds_sin_cos_datapath with a synchronous
//            quarter-wave ROM model and a cycle-level behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_dds_sin_cos_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        freq_clr, freq_load, out_clr, out_load;
  logic [23:0] ftw_i;
  logic        ftw_we_i;
  logic [11:0] sin_o, cos_o;
  logic        valid_o;
  logic [23:0] phase_o;

  int passed = 0;
  int total  = 0;

  dds_sin_cos_datapath_if #(.ADDR_W(8), .DATA_W(12)) rom_if ();

  dds_sin_cos_datapath #(.PHASE_W(24), .ADDR_W(8), .DATA_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .freq_clr  (freq_clr),
    .freq_load (freq_load),
    .out_clr   (out_clr),
    .out_load  (out_load),
    .ftw_i     (ftw_i),
    .ftw_we_i  (ftw_we_i),
    .rom_if    (rom_if.master),
    .sin_o     (sin_o),
    .cos_o     (cos_o),
    .valid_o   (valid_o),
    .phase_o   (phase_o)
  );

  always #5 clk = ~clk;

  // ROM contents: 0 at address 0x00 rising to 0x7FF at address 0xFF.
  function automatic logic [10:0] rom_fn(input logic [7:0] a);
    logic [2:0] top;
    top = a[7:5];
    return {a, top};
  endfunction

  // Synchronous ROM: data appears one cycle after the address.
  always @(posedge clk) begin
    rom_if.rom_sin_data_i <= rom_fn(rom_if.rom_sin_addr_o);
    rom_if.rom_cos_data_i <= rom_fn(rom_if.rom_cos_addr_o);
  end

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int          due;
    logic [11:0] s;
    logic [11:0] c;
  } pend_t;

  pend_t       pend[$];
  int          edge_n = 0;
  logic [23:0] m_phase, m_ftw;
  logic [11:0] m_sin, m_cos;
  logic        m_valid;

  // Sine/cosine from a quarter-wave table, by quadrant symmetry.
  function automatic void ref_sample(input logic [23:0] ph,
                                     output logic [11:0] s, output logic [11:0] c);
    int quad, idx, up, dn;
    quad = int'(ph[23:22]);
    idx  = int'(ph[21:14]);
    up   = int'(rom_fn(8'(idx)));
    dn   = int'(rom_fn(8'(255 - idx)));
    case (quad)
      0:       begin s = 12'(up);  c = 12'(dn);  end
      1:       begin s = 12'(dn);  c = 12'(-up); end
      2:       begin s = 12'(-up); c = 12'(-dn); end
      default: begin s = 12'(-dn); c = 12'(up);  end
    endcase
  endfunction

  task automatic model_clear();
    pend.delete();
    m_phase = '0; m_ftw = '0; m_sin = '0; m_cos = '0; m_valid = 1'b0;
  endtask

  task automatic drive(input logic fc, input logic fl, input logic oc,
                       input logic ol, input logic we, input logic [23:0] f);
    freq_clr = fc; freq_load = fl; out_clr = oc; out_load = ol;
    ftw_we_i = we; ftw_i = f;
  endtask

  // One rising edge: advance the model with the inputs the DUT sampled.
  task automatic step();
    logic [11:0] s, c;
    @(posedge clk);
    edge_n++;
    if (out_clr) begin
      pend.delete();
      m_sin = '0; m_cos = '0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        m_valid = 1'b1;
        m_sin   = pend[0].s;
        m_cos   = pend[0].c;
        void'(pend.pop_front());
      end
    end
    if (freq_clr)       m_phase = '0;
    else if (freq_load) m_phase = m_phase + m_ftw;
    if (ftw_we_i)       m_ftw = ftw_i;
    if (out_load && !out_clr) begin
      ref_sample(m_phase, s, c);
      pend.push_back('{edge_n + 3, s, c});
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    #1;
    model_clear();
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    model_clear();
    step();
    step();
    total++; if (phase_o !== 24'h0) $display("FAIL reset_phase: got %h want 000000", phase_o); else passed++;
    total++; if (sin_o !== 12'h0) $display("FAIL reset_sin: got %h want 000", sin_o); else passed++;
    total++; if (cos_o !== 12'h0) $display("FAIL reset_cos: got %h want 000", cos_o); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
    total++; if (rom_if.rom_sin_addr_o !== 8'h0) $display("FAIL reset_sin_addr: got %h want 00", rom_if.rom_sin_addr_o); else passed++;
    total++; if (rom_if.rom_cos_addr_o !== 8'h0) $display("FAIL reset_cos_addr: got %h want 00", rom_if.rom_cos_addr_o); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_phase_accum();
    do_reset();
    drive(0, 1, 0, 0, 1, 24'h010000);   // load uses the old (zero) FTW
    step();
    total++; if (phase_o !== 24'h0) $display("FAIL old_ftw_phase: got %h want 000000", phase_o); else passed++;
    drive(0, 1, 0, 0, 0, '0);
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (phase_o !== 24'(32'h10000 * k))
        $display("FAIL accum_phase k=%0d: got %h want %h", k, phase_o, 24'(32'h10000 * k));
      else passed++;
    end
  endtask

  task automatic test_wrap_clr();
    do_reset();
    drive(0, 0, 0, 0, 1, 24'h400000); step();
    drive(0, 1, 0, 0, 0, '0); step(); step(); step();
    total++; if (phase_o !== 24'hC00000) $display("FAIL wrap_setup: got %h want C00000", phase_o); else passed++;
    drive(0, 0, 0, 0, 1, 24'h800000); step();
    drive(0, 1, 0, 0, 0, '0); step();
    total++; if (phase_o !== 24'h400000) $display("FAIL wrap_phase: got %h want 400000", phase_o); else passed++;
    drive(1, 1, 0, 0, 0, '0); step();
    total++; if (phase_o !== 24'h0) $display("FAIL clr_beats_load: got %h want 000000", phase_o); else passed++;
    drive(0, 1, 0, 0, 0, '0); step();
    total++; if (phase_o !== 24'h800000) $display("FAIL ftw_kept_after_clr: got %h want 800000", phase_o); else passed++;
  endtask

  task automatic test_quadrant_samples();
    logic [23:0] tgt [2];
    logic [7:0]  ws_a [2], wc_a [2];
    logic [11:0] ws [2], wc [2];
    tgt[0] = 24'h800000; ws_a[0] = 8'h00; wc_a[0] = 8'hFF; ws[0] = 12'h000; wc[0] = 12'h801;
    tgt[1] = 24'h400000; ws_a[1] = 8'hFF; wc_a[1] = 8'h00; ws[1] = 12'h7FF; wc[1] = 12'h000;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      drive(0, 0, 0, 0, 1, tgt[t]); step();
      drive(0, 1, 0, 1, 0, '0);     step();   // edge N
      drive(0, 0, 0, 0, 0, '0);     step();   // N+1
      total++; if (rom_if.rom_sin_addr_o !== ws_a[t]) $display("FAIL quad_sin_addr t=%0d: got %h want %h", t, rom_if.rom_sin_addr_o, ws_a[t]); else passed++;
      total++; if (rom_if.rom_cos_addr_o !== wc_a[t]) $display("FAIL quad_cos_addr t=%0d: got %h want %h", t, rom_if.rom_cos_addr_o, wc_a[t]); else passed++;
      step();                                 // N+2
      step();                                 // N+3
      total++; if (valid_o !== 1'b1) $display("FAIL quad_valid t=%0d: got %b want 1", t, valid_o); else passed++;
      total++; if (sin_o !== ws[t]) $display("FAIL quad_sin t=%0d: got %h want %h", t, sin_o, ws[t]); else passed++;
      total++; if (cos_o !== wc[t]) $display("FAIL quad_cos t=%0d: got %h want %h", t, cos_o, wc[t]); else passed++;
      step();
      total++; if (valid_o !== 1'b0 || sin_o !== ws[t]) $display("FAIL quad_hold t=%0d: got v=%b sin=%h want v=0 sin=%h", t, valid_o, sin_o, ws[t]); else passed++;
    end
  endtask

  task automatic test_latency_clr();
    do_reset();
    drive(0, 0, 0, 0, 1, 24'($urandom)); step();
    drive(0, 1, 0, 1, 0, '0); step();         // edge N
    drive(0, 0, 0, 0, 0, '0);
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (valid_o !== (k == 3) || sin_o !== m_sin || cos_o !== m_cos)
        $display("FAIL latency N+%0d: got v=%b sin=%h cos=%h want v=%b sin=%h cos=%h",
                 k, valid_o, sin_o, cos_o, (k == 3), m_sin, m_cos);
      else passed++;
    end
    drive(0, 1, 0, 1, 0, '0); step();         // edge N
    drive(0, 0, 0, 0, 0, '0); step();         // N+1
    drive(0, 0, 1, 0, 0, '0); step();         // N+2 clears
    drive(0, 0, 0, 0, 0, '0);
    for (int k = 3; k <= 5; k++) begin
      step();
      total++;
      if (valid_o !== 1'b0 || sin_o !== 12'h0 || cos_o !== 12'h0)
        $display("FAIL out_clr N+%0d: got v=%b sin=%h cos=%h want v=0 sin=000 cos=000",
                 k, valid_o, sin_o, cos_o);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    do_reset();
    drive(0, 0, 0, 0, 1, 24'($urandom)); step();
    for (int k = 0; k < 12; k++) begin
      if (k < 6) drive(0, 1, 0, 1, 0, '0); else drive(0, 0, 0, 0, 0, '0);
      step();
      if (valid_o === 1'b1) pulses++;
      total++;
      if (valid_o !== m_valid || sin_o !== m_sin || cos_o !== m_cos)
        $display("FAIL b2b k=%0d: got v=%b sin=%h cos=%h want v=%b sin=%h cos=%h",
                 k, valid_o, sin_o, cos_o, m_valid, m_sin, m_cos);
      else passed++;
    end
    total++; if (pulses != 6) $display("FAIL b2b_pulse_count: got %0d want 6", pulses); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) == 0, 24'($urandom));
      step();
      total++;
      if (phase_o !== m_phase || valid_o !== m_valid || sin_o !== m_sin || cos_o !== m_cos)
        $display("FAIL random i=%0d: got ph=%h v=%b sin=%h cos=%h want ph=%h v=%b sin=%h cos=%h",
                 i, phase_o, valid_o, sin_o, cos_o, m_phase, m_valid, m_sin, m_cos);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(0, 0, 0, 0, 1, 24'($urandom) | 24'h000001); step();
    drive(0, 1, 0, 1, 0, '0); step(); step(); step();   // three loads in flight
    drive(0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    #1;
    model_clear();
    total++;
    if (phase_o !== 24'h0 || sin_o !== 12'h0 || cos_o !== 12'h0 || valid_o !== 1'b0 ||
        rom_if.rom_sin_addr_o !== 8'h0 || rom_if.rom_cos_addr_o !== 8'h0)
      $display("FAIL mid_reset_zero: got ph=%h sin=%h cos=%h v=%b sa=%h ca=%h want all 0",
               phase_o, sin_o, cos_o, valid_o, rom_if.rom_sin_addr_o, rom_if.rom_cos_addr_o);
    else passed++;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (valid_o !== 1'b0) $display("FAIL mid_reset_no_valid k=%0d: got %b want 0", k, valid_o); else passed++;
    end
    drive(0, 0, 0, 1, 0, '0); step();
    drive(0, 0, 0, 0, 0, '0); step(); step(); step();
    total++;
    if (valid_o !== 1'b1 || sin_o !== m_sin || cos_o !== m_cos)
      $display("FAIL post_reset_load: got v=%b sin=%h cos=%h want v=1 sin=%h cos=%h",
               valid_o, sin_o, cos_o, m_sin, m_cos);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_phase_accum();
    test_wrap_clr();
    test_quadrant_samples();
    test_latency_clr();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
